// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory responder: per-channel handshake state and operation kind.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2,
    ACK      = 2'd3
  } chan_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int LATENCY_CNT_BITS = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts one past the last granted index.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic                enable,
  output logic [N-1:0]        grant_onehot,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [IDX_BITS-1:0] ptr_q, ptr_d;

  always_comb begin : search
    logic [IDX_BITS-1:0] cand;
    cand         = '0;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_BITS'((int'(ptr_q) + i) % N);
      if (enable && !grant_valid && req[cand]) begin
        grant_valid        = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  assign ptr_d = grant_valid ? grant_idx : ptr_q;

  // Reset to N-1 so channel 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= IDX_BITS'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-channel data-memory responder: per-channel 4-phase handshake FSMs sharing one
// single-port RAM through a round-robin arbiter; responses appear LATENCY cycles after grant.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int LATENCY       = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  input  logic                                    init_write_enable,
  input  logic [ADDR_BITS-1:0]                    init_address,
  input  logic [DATA_BITS-1:0]                    init_data,
  output logic                                    busy,
  output logic [NUM_CONSUMERS-1:0][1:0]           debug_state
);

  localparam int N        = NUM_CONSUMERS;
  localparam int IDX_BITS = (N > 1) ? $clog2(N) : 1;
  localparam logic [LATENCY_CNT_BITS-1:0] CNT_INIT = LATENCY_CNT_BITS'(LATENCY - 1);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  logic [N-1:0]         req;
  logic [N-1:0]         grant_onehot;
  logic [IDX_BITS-1:0]  grant_idx;
  logic                 grant_valid;
  logic [N-1:0]         chan_is_write;
  logic [N-1:0]         chan_active_d;
  logic [ADDR_BITS-1:0] chan_addr  [N];
  logic [DATA_BITS-1:0] chan_wdata [N];
  logic                 busy_q;

  rr_arbiter #(.N(N), .IDX_BITS(IDX_BITS)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .enable       (!init_write_enable),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  for (genvar g = 0; g < N; g++) begin : g_chan
    chan_state_t                 state_q, state_d;
    op_t                         op_q, op_d;
    logic [LATENCY_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]        addr_q, addr_d;
    logic [DATA_BITS-1:0]        wdata_q, wdata_d;
    logic [DATA_BITS-1:0]        rdata_q;
    logic                        op_valid;
    logic                        rd_ready, wr_ready;

    assign op_valid = (op_q == OP_READ) ? consumer_read_valid[g] : consumer_write_valid[g];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        op_q    <= OP_READ;
        cnt_q   <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
      end else begin
        state_q <= state_d;
        op_q    <= op_d;
        cnt_q   <= cnt_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
      end
    end

    // Read wins when both valids are high; the write stays raised and is picked up next IDLE.
    always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
        IDLE: begin
          if (consumer_read_valid[g]) begin
            state_d = PENDING;
            op_d    = OP_READ;
            addr_d  = consumer_read_address[g];
          end else if (consumer_write_valid[g]) begin
            state_d = PENDING;
            op_d    = OP_WRITE;
            addr_d  = consumer_write_address[g];
            wdata_d = consumer_write_data[g];
          end
        end
        PENDING: begin
          if (grant_onehot[g]) begin
            state_d = INFLIGHT;
            cnt_d   = CNT_INIT;
          end
        end
        INFLIGHT: begin
          if (cnt_q == '0) state_d = ACK;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ACK: begin
          if (!op_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      rd_ready = 1'b0;
      wr_ready = 1'b0;
      if (state_q == ACK) begin
        if (op_q == OP_READ) rd_ready = 1'b1;
        else                 wr_ready = 1'b1;
      end
    end

    // Captures the pre-write RAM word at the grant edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 rdata_q <= '0;
      else if (grant_onehot[g] && op_q == OP_READ) rdata_q <= mem[addr_q];
    end

    assign req[g]                  = (state_q == PENDING);
    assign chan_is_write[g]        = (op_q == OP_WRITE);
    assign chan_addr[g]            = addr_q;
    assign chan_wdata[g]           = wdata_q;
    assign chan_active_d[g]        = (state_d != IDLE);
    assign consumer_read_ready[g]  = rd_ready;
    assign consumer_write_ready[g] = wr_ready;
    assign consumer_read_data[g]   = rdata_q;
    assign debug_state[g]          = state_q;
  end

  // Init never collides with a granted write: the arbiter is disabled while init is active.
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (init_write_enable) begin
      mem_we    = 1'b1;
      mem_waddr = init_address;
      mem_wdata = init_data;
    end else if (grant_valid && chan_is_write[grant_idx]) begin
      mem_we    = 1'b1;
      mem_waddr = chan_addr[grant_idx];
      mem_wdata = chan_wdata[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= |chan_active_d;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder using a transaction-level
// round-robin/memory reference model.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         rd_valid, rd_ready, wr_valid, wr_ready;
  logic [N-1:0][AW-1:0] rd_addr, wr_addr;
  logic [N-1:0][DW-1:0] rd_data, wr_data;
  logic                 init_we;
  logic [AW-1:0]        init_addr;
  logic [DW-1:0]        init_data;
  logic                 busy;
  logic [N-1:0][1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // Reference model: memory image plus the last channel the round-robin granted.
  logic [DW-1:0] model_mem [2**AW];
  int            last_grant = N - 1;

  // Current batch of transactions, one per channel at most.
  logic [N-1:0]  b_mask, b_write;
  logic [AW-1:0] b_addr  [N];
  logic [DW-1:0] b_wdata [N];
  int            b_hold;

  data_mem_responder #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .LATENCY(LAT)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rd_valid),
    .consumer_read_address  (rd_addr),
    .consumer_read_ready    (rd_ready),
    .consumer_read_data     (rd_data),
    .consumer_write_valid   (wr_valid),
    .consumer_write_address (wr_addr),
    .consumer_write_data    (wr_data),
    .consumer_write_ready   (wr_ready),
    .init_write_enable      (init_we),
    .init_address           (init_addr),
    .init_data              (init_data),
    .busy                   (busy),
    .debug_state            (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    rd_valid = '0;
    wr_valid = '0;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    last_grant = N - 1;
    @(negedge clk);
  endtask

  task automatic clear_batch();
    b_mask  = '0;
    b_write = '0;
    b_hold  = 0;
  endtask

  task automatic add_txn(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    b_mask[c]  = 1'b1;
    b_write[c] = w;
    b_addr[c]  = a;
    b_wdata[c] = d;
  endtask

  // Issues the batch simultaneously; the model orders grants by round-robin distance
  // from the last grant and replays them against model_mem in that order.
  task automatic run_batch(input string name);
    int            key [N];
    int            rank [N];
    int            exp_cyc [N];
    logic [DW-1:0] exp_rd [N];
    int            phase [N];
    int            held [N];
    logic          rdy;
    logic [DW-1:0] dat;
    bit            all_done;
    for (int c = 0; c < N; c++) key[c] = (c - last_grant - 1 + 2 * N) % N;
    for (int c = 0; c < N; c++) begin
      rank[c] = 0;
      exp_rd[c] = '0;
      exp_cyc[c] = 0;
      for (int j = 0; j < N; j++)
        if (b_mask[c] && b_mask[j] && key[j] < key[c]) rank[c]++;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (b_mask[c] && rank[c] == r) begin
          if (b_write[c]) model_mem[b_addr[c]] = b_wdata[c];
          else            exp_rd[c] = model_mem[b_addr[c]];
          exp_cyc[c] = 2 + r + LAT;
          last_grant = c;
        end
    for (int c = 0; c < N; c++) begin
      held[c]  = 0;
      phase[c] = b_mask[c] ? 0 : 3;
      if (b_mask[c] && b_write[c]) begin
        wr_addr[c]  = b_addr[c];
        wr_data[c]  = b_wdata[c];
        wr_valid[c] = 1'b1;
      end else if (b_mask[c]) begin
        rd_addr[c]  = b_addr[c];
        rd_valid[c] = 1'b1;
      end
    end
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check({name, "_busy_active"}, 32'(busy), 32'(1));
      all_done = 1'b1;
      for (int c = 0; c < N; c++) begin
        rdy = b_write[c] ? wr_ready[c] : rd_ready[c];
        dat = rd_data[c];
        case (phase[c])
          0: if (rdy) begin
               check($sformatf("%s_ch%0d_ready_cycle", name, c), 32'(cyc), 32'(exp_cyc[c]));
               if (!b_write[c]) check($sformatf("%s_ch%0d_rdata", name, c), 32'(dat), 32'(exp_rd[c]));
               phase[c] = 1;
             end
          1: begin
               held[c]++;
               check($sformatf("%s_ch%0d_ready_hold", name, c), 32'(rdy), 32'(1));
               if (!b_write[c]) check($sformatf("%s_ch%0d_rdata_hold", name, c), 32'(dat), 32'(exp_rd[c]));
             end
          2: begin
               check($sformatf("%s_ch%0d_ready_fall", name, c), 32'(rdy), 32'(0));
               phase[c] = 3;
             end
          default: ;
        endcase
        if (phase[c] == 1 && held[c] >= b_hold) begin
          rd_valid[c] = 1'b0;
          wr_valid[c] = 1'b0;
          phase[c]    = 2;
        end
        if (phase[c] != 3) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int c = 0; c < N; c++)
      if (phase[c] != 3) check($sformatf("%s_ch%0d_timeout", name, c), 32'(phase[c]), 32'(3));
    check({name, "_busy_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin : stim
    int seen;
    reset     = 1'b1;
    rd_valid  = '0;
    wr_valid  = '0;
    rd_addr   = '0;
    wr_addr   = '0;
    wr_data   = '0;
    init_we   = 1'b0;
    init_addr = '0;
    init_data = '0;
    clear_batch();
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_rd_ready", 32'(rd_ready), 32'(0));
    check("reset_wr_ready", 32'(wr_ready), 32'(0));
    check("reset_rd_data", 32'(rd_data), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single read with data held for two extra cycles.
    preload(8'h10, 8'hA5);
    clear_batch();
    add_txn(0, 1'b0, 8'h10, 8'h00);
    b_hold = 2;
    run_batch("t1");

    // Write then read from another channel.
    clear_batch();
    add_txn(1, 1'b1, 8'h20, 8'h3C);
    run_batch("t2w");
    clear_batch();
    add_txn(2, 1'b0, 8'h20, 8'h00);
    run_batch("t2r");

    // All four read at once straight after reset.
    apply_reset();
    for (int c = 0; c < N; c++) preload(AW'(8'h30 + c), DW'(8'hC0 + c));
    clear_batch();
    for (int c = 0; c < N; c++) add_txn(c, 1'b0, AW'(8'h30 + c), 8'h00);
    run_batch("t3");

    // Channel 0 just served, so the next full round must serve it last.
    apply_reset();
    clear_batch();
    add_txn(0, 1'b0, 8'h10, 8'h00);
    run_batch("t4a");
    clear_batch();
    for (int c = 0; c < N; c++) add_txn(c, 1'b0, AW'(8'h30 + c), 8'h00);
    run_batch("t4b");

    // Reset while channel 0 is in flight.
    preload(8'h40, 8'h77);
    rd_addr[0]  = 8'h40;
    rd_valid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_inflight", 32'(dbg_state[0]), 32'(INFLIGHT));
    #1 reset = 1'b1;
    #1;
    check("t5_async_ready", 32'(rd_ready), 32'(0));
    check("t5_async_busy", 32'(busy), 32'(0));
    check("t5_async_rdata", 32'(rd_data[0]), 32'(0));
    check("t5_async_state", 32'(dbg_state[0]), 32'(IDLE));
    rd_valid[0] = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    last_grant = N - 1;
    repeat (3) @(negedge clk);
    check("t5_stays_idle", 32'(dbg_state[0]), 32'(IDLE));
    check("t5_no_ready", 32'(rd_ready[0]), 32'(0));
    clear_batch();
    add_txn(0, 1'b0, 8'h40, 8'h00);
    run_batch("t5r");

    // Init strobe held three cycles while channel 3 waits for its grant.
    preload(8'h50, 8'h11);
    rd_addr[3]  = 8'h50;
    rd_valid[3] = 1'b1;
    @(negedge clk);
    check("t6_pending", 32'(dbg_state[3]), 32'(PENDING));
    init_we   = 1'b1;
    init_addr = 8'h50;
    init_data = 8'h99;
    repeat (3) @(negedge clk);
    init_we = 1'b0;
    model_mem[8'h50] = 8'h99;
    check("t6_still_pending", 32'(dbg_state[3]), 32'(PENDING));
    seen = 0;
    for (int cyc = 5; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (rd_ready[3]) begin
        seen = cyc;
        break;
      end
    end
    check("t6_ready_cycle", 32'(seen), 32'(4 + 1 + LAT));
    check("t6_rdata", 32'(rd_data[3]), 32'(model_mem[8'h50]));
    rd_valid[3] = 1'b0;
    @(negedge clk);
    check("t6_ready_fall", 32'(rd_ready[3]), 32'(0));
    last_grant = 3;

    // Random mixed batches over a small address window so channels collide.
    for (int a = 0; a < 4; a++) preload(AW'(8'h60 + a), DW'($urandom));
    for (int t = 0; t < 20; t++) begin
      clear_batch();
      b_mask = N'($urandom_range(1, 2**N - 1));
      for (int c = 0; c < N; c++)
        if (b_mask[c]) add_txn(c, 1'($urandom_range(0, 1)), AW'(8'h60 + $urandom_range(0, 3)), DW'($urandom));
      b_hold = $urandom_range(0, 2);
      run_batch($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
